monster_pixel_fetch: RTL
========================

Name: monster_pixel_fetch

Overview:
- Downstream/driving stage for the 8-port monster sprite ROM: 22x22 sprite, 484 entries of 4-bit palette index, 1-cycle registered read.
- For each pixel position from the VGA controller, tests all 8 monster bounding boxes and computes the 8 ROM read addresses.
- Consumes the 8 ROM outputs and resolves priority and transparency.
- Emits one pipelined palette index plus a per-monster hit mask to the colour mapper.

Parameters:
- SPR_W, 22, sprite width in pixels
- SPR_H, 22, sprite height in pixels
- TRANSP, 4'h0, palette index treated as transparent
- N_MON, 8, monster count (fixed at 8 to match ROM ports)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  DrawX/DrawY are valid this cycle (active display)
- DrawX  in  10  current pixel column, 0..639
- DrawY  in  10  current pixel row, 0..479
- mon_x  in  80  8x10-bit top-left X; monster k at [10k+9:10k]
- mon_y  in  80  8x10-bit top-left Y, same packing
- mon_alive  in  8  bit k = monster k drawn
- mon_flip  in  8  bit k = mirror monster k horizontally
- read_address1..read_address8  out  19 each  ROM addresses, monster 0..7
- data_In1..data_In8  in  4 each  ROM data, 1 cycle after address
- pix_index  out  4  resolved palette index
- pix_hit  out  1  an opaque monster pixel is present
- hit_mask  out  8  monsters with an opaque pixel here, before priority
- pix_out_valid  out  1  pix_index/pix_hit/hit_mask valid

Behaviour:
- Pipeline: inputs sampled at edge N; read_addressK registered at N+1; ROM data at N+2; outputs registered at N+3. Fixed latency 3, one pixel per cycle, no stalls.
- Box test per monster k: dx = {1'b0,DrawX} - {1'b0,mon_x[k]} and dy likewise, both 11-bit.
  - in_box_k = mon_alive[k] & pix_valid & ~dx[10] & ~dy[10] & dx < SPR_W & dy < SPR_H.
  - Sign bit set (wrap) means outside the box.
- Address for in-box monster k: dy*SPR_W + col, where col = mon_flip[k] ? (SPR_W-1-dx) : dx; zero-extended to 19 bits, range 0..483.
- Out-of-box address is forced to 0 so the ROM never reads out of range.
- Stage 1 registers: in_box_k and pix_valid.
- Stage 2 registers: the stage-1 values again, aligned with ROM data.
- Opaque_k = in_box_k(stage2) & (data_InK != TRANSP).
- Stage 3 outputs:
  - hit_mask = opaque vector.
  - pix_hit = |opaque.
  - pix_index = data of the lowest-numbered opaque monster (monster 0 highest priority), else TRANSP.
  - pix_out_valid = stage-2 pix_valid.
- pix_valid low: all in_box forced 0, addresses 0, and pix_out_valid is low 3 cycles later.
- Positions near screen edges:
  - Boxes extending past 639/479 clip naturally, since DrawX/DrawY never reach there.
  - mon_x/mon_y up to 1023 are legal; the monster is invisible if the box is off-screen.
- mon_* inputs may change on any cycle. They affect only pixels sampled at or after the change; there is no frame-boundary latching in this block.
- Reset (asynchronous assert, any cycle including mid-line):
  - All pipeline registers clear.
  - read_address1..8 = 0, pix_index = TRANSP, pix_hit = 0, hit_mask = 0, pix_out_valid = 0.
  - The first valid output appears 3 cycles after the first pix_valid following deassert.
- No state beyond the pipeline. No multiplier is required; dy*22 = (dy<<4)+(dy<<2)+(dy<<1).

Test Plan:
- Monster 0 at (100,50), alive, no flip; pixels (100,50) and (121,71) -> read_address1 = 0 and 483 one cycle later; with the ROM model, pix_index = mem[0] / mem[483] at N+3, pix_out_valid = 1.
- Same monster, mon_flip[0] = 1; pixel (100,51) -> read_address1 = 22+21 = 43; pixel (121,51) -> 22.
- Boundaries: pixels (99,50), (122,50), (100,49), (100,72) -> in_box 0, read_address1 = 0, pix_hit = 0, hit_mask = 0, pix_index = TRANSP.
- Overlap: monsters 2 and 5 both at (300,200), ROM entry 0 = 4'h7; pixel (300,200) -> hit_mask = 8'b0010_0100, pix_index = 4'h7, pix_hit = 1. Then ROM entry for monster 2's location forced to TRANSP -> pix_index taken from monster 5, hit_mask = 8'b0010_0000.
- Wrap and dead monsters:
  - Monster 3 at (630,0), pixel (5,0) -> no hit, since dx wraps with sign bit set.
  - mon_alive = 0 at an otherwise-hit pixel -> no hit, address 0.
- Streaming plus reset: feed a continuous 640-pixel line with pix_valid = 1 and check outputs match the reference model at exactly 3-cycle lag. Assert Reset_n low mid-line -> all outputs 0/TRANSP immediately (asynchronous); after release, pix_out_valid rises exactly 3 cycles after pix_valid resumes.

Source files
------------

// File: rtl/monster_pixel_fetch_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// monster_pixel_fetch_if : pixel stream, monster table, 8-port ROM and
// resolved-pixel signals of the monster pixel fetch stage.  Rev 1.0
// ----------------------------------------------------------------------------
interface monster_pixel_fetch_if;
  logic        pix_valid;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [79:0] mon_x;
  logic [79:0] mon_y;
  logic [7:0]  mon_alive;
  logic [7:0]  mon_flip;
  logic [18:0] read_address1, read_address2, read_address3, read_address4;
  logic [18:0] read_address5, read_address6, read_address7, read_address8;
  logic [3:0]  data_In1, data_In2, data_In3, data_In4;
  logic [3:0]  data_In5, data_In6, data_In7, data_In8;
  logic [3:0]  pix_index;
  logic        pix_hit;
  logic [7:0]  hit_mask;
  logic        pix_out_valid;

  modport master (
    input  pix_valid, DrawX, DrawY, mon_x, mon_y, mon_alive, mon_flip,
    output read_address1, read_address2, read_address3, read_address4,
    output read_address5, read_address6, read_address7, read_address8,
    input  data_In1, data_In2, data_In3, data_In4,
    input  data_In5, data_In6, data_In7, data_In8,
    output pix_index, pix_hit, hit_mask, pix_out_valid
  );

  modport slave (
    output pix_valid, DrawX, DrawY, mon_x, mon_y, mon_alive, mon_flip,
    input  read_address1, read_address2, read_address3, read_address4,
    input  read_address5, read_address6, read_address7, read_address8,
    output data_In1, data_In2, data_In3, data_In4,
    output data_In5, data_In6, data_In7, data_In8,
    input  pix_index, pix_hit, hit_mask, pix_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/monster_pixel_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// monster_pixel_fetch : box test + ROM addressing for 8 monsters, then
// priority/transparency resolve; fixed 3-cycle pipeline.  Rev 1.0
// ----------------------------------------------------------------------------
module monster_pixel_fetch #(
  parameter int          SPR_W  = 22,
  parameter int          SPR_H  = 22,
  parameter logic [3:0]  TRANSP = 4'h0,
  parameter int          N_MON  = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  monster_pixel_fetch_if.master bus
);

  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);
  localparam logic [18:0] SPR_W19 = 19'(SPR_W);

  logic [10:0]      dx_w    [N_MON];
  logic [10:0]      dy_w    [N_MON];
  logic [10:0]      col_w   [N_MON];
  logic [3:0]       rom_data_w [N_MON];
  logic [N_MON-1:0] in_box_w;
  logic [N_MON-1:0] opaque_w;

  logic [18:0]      addr_d  [N_MON];
  logic [18:0]      addr_q  [N_MON];
  logic [N_MON-1:0] in_box1_d, in_box1_q, in_box2_d, in_box2_q;
  logic             valid1_d, valid1_q, valid2_d, valid2_q;
  logic [3:0]       pix_index_d, pix_index_q;
  logic             pix_hit_d, pix_hit_q;
  logic [N_MON-1:0] hit_mask_d, hit_mask_q;
  logic             out_valid_d, out_valid_q;

  assign rom_data_w[0] = bus.data_In1;
  assign rom_data_w[1] = bus.data_In2;
  assign rom_data_w[2] = bus.data_In3;
  assign rom_data_w[3] = bus.data_In4;
  assign rom_data_w[4] = bus.data_In5;
  assign rom_data_w[5] = bus.data_In6;
  assign rom_data_w[6] = bus.data_In7;
  assign rom_data_w[7] = bus.data_In8;

  // Stage 0: a negative offset shows up as bit 10 set and lands outside the box.
  always_comb begin
    for (int k = 0; k < N_MON; k++) begin
      dx_w[k] = {1'b0, bus.DrawX} - {1'b0, bus.mon_x[10*k +: 10]};
      dy_w[k] = {1'b0, bus.DrawY} - {1'b0, bus.mon_y[10*k +: 10]};
      in_box_w[k] = bus.mon_alive[k] & bus.pix_valid & ~dx_w[k][10] & ~dy_w[k][10]
                  & (dx_w[k] < SPR_W11) & (dy_w[k] < SPR_H11);
      col_w[k] = bus.mon_flip[k] ? (SPR_W11 - 11'd1 - dx_w[k]) : dx_w[k];
      // Constant multiply folds to shift-add; out-of-box reads park on entry 0.
      addr_d[k] = in_box_w[k] ? (19'(dy_w[k]) * SPR_W19 + 19'(col_w[k])) : '0;
    end
  end

  always_comb begin
    in_box1_d = in_box_w;
    valid1_d  = bus.pix_valid;
    in_box2_d = in_box1_q;
    valid2_d  = valid1_q;
    for (int k = 0; k < N_MON; k++) begin
      opaque_w[k] = in_box2_q[k] & (rom_data_w[k] != TRANSP);
    end
    // Walk downward so the lowest-numbered opaque monster wins.
    pix_index_d = TRANSP;
    for (int k = N_MON - 1; k >= 0; k--) begin
      if (opaque_w[k]) begin
        pix_index_d = rom_data_w[k];
      end
    end
    pix_hit_d   = |opaque_w;
    hit_mask_d  = opaque_w;
    out_valid_d = valid2_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < N_MON; k++) begin
        addr_q[k] <= '0;
      end
      in_box1_q   <= '0;
      valid1_q    <= 1'b0;
      in_box2_q   <= '0;
      valid2_q    <= 1'b0;
      pix_index_q <= TRANSP;
      pix_hit_q   <= 1'b0;
      hit_mask_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_MON; k++) begin
        addr_q[k] <= addr_d[k];
      end
      in_box1_q   <= in_box1_d;
      valid1_q    <= valid1_d;
      in_box2_q   <= in_box2_d;
      valid2_q    <= valid2_d;
      pix_index_q <= pix_index_d;
      pix_hit_q   <= pix_hit_d;
      hit_mask_q  <= hit_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.read_address1 = addr_q[0];
  assign bus.read_address2 = addr_q[1];
  assign bus.read_address3 = addr_q[2];
  assign bus.read_address4 = addr_q[3];
  assign bus.read_address5 = addr_q[4];
  assign bus.read_address6 = addr_q[5];
  assign bus.read_address7 = addr_q[6];
  assign bus.read_address8 = addr_q[7];
  assign bus.pix_index     = pix_index_q;
  assign bus.pix_hit       = pix_hit_q;
  assign bus.hit_mask      = hit_mask_q;
  assign bus.pix_out_valid = out_valid_q;

endmodule
`default_nettype wire
